// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 encryption core.
// Contents: round count, FSM state type, Rcon lookup, and the GF(2^8)
// and byte-permutation helpers used by the round datapath.
// Byte order everywhere: byte i of a 128-bit word sits at [127-8i -: 8],
// and byte i maps to state[i%4][i/4] (column-major).
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Round constant for round rnd (1..10); other indices are unused.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; a0 is the top byte (row 0).
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Row r rotates left by r columns: out[r][c] = in[r][(c+r)%4].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational.
// Ports: din - input byte; dout - substituted byte.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/aes_engine.sv
// Iterative AES-128 encryption core: one round per clock, round keys
// expanded on the fly. A block is accepted while idle, finishes 10 edges
// later with a one-cycle c_gecerli pulse; throughput 1 block / 11 cycles.
// Ports:
//   clk, rst (async active-low)
//   anahtar   - 128-bit key, byte 0 in [127:120]
//   blok      - 128-bit plaintext, byte 0 in [127:120]
//   g_gecerli - input valid, taken when hazir=1
//   hazir     - ready (idle)
//   sifre     - ciphertext, held until the next completion
//   c_gecerli - one-cycle pulse when sifre updates
module aes_engine
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] anahtar,
  input  logic [127:0] blok,
  input  logic         g_gecerli,
  output logic         hazir,
  output logic [127:0] sifre,
  output logic         c_gecerli
);

  state_e       fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] sifre_q, sifre_d;
  logic         c_gecerli_q, c_gecerli_d;
  logic         hazir_q, hazir_d;

  // Round datapath: SubBytes -> ShiftRows -> MixColumns
  logic [127:0] sb_state;
  logic [127:0] sr_state;
  logic [127:0] mc_state;

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    aes_sbox u_sbox (
      .din  (state_q[127-8*i -: 8]),
      .dout (sb_state[127-8*i -: 8])
    );
  end

  assign sr_state = shift_rows(sb_state);

  always_comb begin
    mc_state = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      mc_state[127-32*c -: 32] = mix_column(sr_state[127-32*c -: 32]);
    end
  end

  // Key schedule: next round key from the current one
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [31:0]  t_w;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [127:0] rk_next;

  assign rot_w = rot_word(rk_q[31:0]);

  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    aes_sbox u_sbox (
      .din  (rot_w[31-8*j -: 8]),
      .dout (sub_w[31-8*j -: 8])
    );
  end

  assign t_w     = sub_w ^ {rcon(rnd_q), 24'h0};
  assign w0_n    = rk_q[127:96] ^ t_w;
  assign w1_n    = rk_q[95:64]  ^ w0_n;
  assign w2_n    = rk_q[63:32]  ^ w1_n;
  assign w3_n    = rk_q[31:0]   ^ w2_n;
  assign rk_next = {w0_n, w1_n, w2_n, w3_n};

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rk_d        = rk_q;
    rnd_d       = rnd_q;
    sifre_d     = sifre_q;
    c_gecerli_d = 1'b0;
    hazir_d     = hazir_q;
    unique case (fsm_q)
      IDLE: begin
        if (g_gecerli) begin
          state_d = blok ^ anahtar;
          rk_d    = anahtar;
          rnd_d   = 4'd1;
          fsm_d   = BUSY;
          hazir_d = 1'b0;
        end
      end
      BUSY: begin
        rk_d  = rk_next;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'(NR)) begin
          // Final round skips MixColumns and goes straight to the output
          sifre_d     = sr_state ^ rk_next;
          c_gecerli_d = 1'b1;
          fsm_d       = IDLE;
          hazir_d     = 1'b1;
        end else begin
          state_d = mc_state ^ rk_next;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rk_q        <= '0;
      rnd_q       <= '0;
      sifre_q     <= '0;
      c_gecerli_q <= 1'b0;
      hazir_q     <= 1'b1;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rk_q        <= rk_d;
      rnd_q       <= rnd_d;
      sifre_q     <= sifre_d;
      c_gecerli_q <= c_gecerli_d;
      hazir_q     <= hazir_d;
    end
  end

  assign hazir     = hazir_q;
  assign sifre     = sifre_q;
  assign c_gecerli = c_gecerli_q;

endmodule

// File: tb/tb_aes_engine.sv
// Bench for aes_engine: a transaction-level AES-128 model (S-box derived
// from GF(2^8) inversion plus the affine map) predicts hazir, c_gecerli
// and sifre every cycle; directed FIPS-197 vectors pin the model and DUT.
module tb_aes_engine;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KE = 128'h657870616e642033322d62797465206b;
  localparam logic [127:0] PQ = 128'h71776572747975696f70617364666768;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] anahtar = '0;
  logic [127:0] blok = '0;
  logic         g_gecerli = 1'b0;
  logic         hazir;
  logic [127:0] sifre;
  logic         c_gecerli;

  int vectors = 0;
  int miscompares = 0;

  aes_engine dut (
    .clk       (clk),
    .rst       (rst),
    .anahtar   (anahtar),
    .blok      (blok),
    .g_gecerli (g_gecerli),
    .hazir     (hazir),
    .sifre     (sifre),
    .c_gecerli (c_gecerli)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference AES-128 ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] w [4];
    logic [7:0] rc;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      w[0] = sbox_f(k[13]) ^ rc;
      w[1] = sbox_f(k[14]);
      w[2] = sbox_f(k[15]);
      w[3] = sbox_f(k[12]);
      for (int i = 0; i < 4; i++) k[i] = k[i] ^ w[i];
      for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
      rc = gmul(rc, 8'h02);
      for (int i = 0; i < 16; i++) s[i] = sbox_f(s[i]);
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          t[row+4*col] = s[row+4*((col+row)%4)];
      for (int col = 0; col < 4; col++) begin
        if (r < 10) begin
          s[4*col+0] = gmul(t[4*col], 2) ^ gmul(t[4*col+1], 3) ^ t[4*col+2] ^ t[4*col+3];
          s[4*col+1] = t[4*col] ^ gmul(t[4*col+1], 2) ^ gmul(t[4*col+2], 3) ^ t[4*col+3];
          s[4*col+2] = t[4*col] ^ t[4*col+1] ^ gmul(t[4*col+2], 2) ^ gmul(t[4*col+3], 3);
          s[4*col+3] = gmul(t[4*col], 3) ^ t[4*col+1] ^ t[4*col+2] ^ gmul(t[4*col+3], 2);
        end else begin
          for (int row = 0; row < 4; row++) s[4*col+row] = t[4*col+row];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- transaction/timing model ----------------
  int           m_cnt = 0;
  logic [127:0] m_pend = '0;
  logic [127:0] m_sifre = '0;
  logic         m_valid = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt   = 0;
      m_sifre = '0;
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_cnt == 0) begin
        if (g_gecerli) begin
          m_pend = aes(anahtar, blok);
          m_cnt  = 10;
        end
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_sifre = m_pend;
          m_valid = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_hazir", {127'b0, hazir}, {127'b0, (m_cnt == 0)});
    chk("cyc_c_gecerli", {127'b0, c_gecerli}, {127'b0, m_valid});
    chk("cyc_sifre", sifre, m_sifre);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  // Pulses g_gecerli for one accept edge and returns cycles to c_gecerli (0 = none).
  task automatic run_block(input logic [127:0] key, input logic [127:0] pt, output int lat);
    anahtar   = key;
    blok      = pt;
    g_gecerli = 1'b1;
    step();
    g_gecerli = 1'b0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (c_gecerli) begin
        lat = i;
        break;
      end
      chk("busy_hazir", {127'b0, hazir}, 128'd0);
    end
    if (lat == 0) begin
      miscompares++;
      $display("FAIL timeout: no c_gecerli within 30 cycles");
    end
  endtask

  int lat;
  int last_pulse;
  int npulse;
  logic [127:0] saved;

  initial begin
    #1 rst = 1'b0;
    g_gecerli = 1'b1;
    anahtar   = KB;
    blok      = PB;
    repeat (5) step();
    chk("rst_hazir", {127'b0, hazir}, 128'd1);
    chk("rst_c_gecerli", {127'b0, c_gecerli}, 128'd0);
    chk("rst_sifre", sifre, 128'd0);
    g_gecerli = 1'b0;
    rst = 1'b1;
    step();

    chk("model_appB", aes(KB, PB), CB);
    chk("model_appC1", aes(KC, PC), CC);

    run_block(KB, PB, lat);
    chk("appB_latency", 128'(lat), 128'd10);
    chk("appB_sifre", sifre, CB);
    chk("appB_hazir_at_pulse", {127'b0, hazir}, 128'd1);
    step();
    chk("appB_pulse_width", {127'b0, c_gecerli}, 128'd0);

    run_block(KC, PC, lat);
    chk("appC1_latency", 128'(lat), 128'd10);
    chk("appC1_sifre", sifre, CC);

    saved = sifre;
    repeat (20) begin
      step();
      chk("idle_sifre", sifre, saved);
      chk("idle_c_gecerli", {127'b0, c_gecerli}, 128'd0);
      chk("idle_hazir", {127'b0, hazir}, 128'd1);
    end

    // Continuous valid; blok scrambled whenever the core is busy
    anahtar    = KE;
    blok       = PQ;
    g_gecerli  = 1'b1;
    last_pulse = -1;
    npulse     = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (c_gecerli) begin
        chk("cont_sifre", sifre, aes(KE, PQ));
        if (last_pulse >= 0) chk("cont_interval", 128'(i - last_pulse), 128'd11);
        last_pulse = i;
        npulse++;
      end
      blok = hazir ? PQ : {$urandom, $urandom, $urandom, $urandom};
    end
    chk("cont_pulses", 128'(npulse), 128'd3);
    g_gecerli = 1'b0;
    blok      = PQ;
    repeat (15) step();

    // Reset in the middle of the App. B block
    anahtar   = KB;
    blok      = PB;
    g_gecerli = 1'b1;
    step();
    g_gecerli = 1'b0;
    repeat (4) step();
    rst = 1'b0;
    step();
    chk("midrst_sifre", sifre, 128'd0);
    step();
    rst = 1'b1;
    repeat (15) begin
      step();
      chk("midrst_no_pulse", {127'b0, c_gecerli}, 128'd0);
    end
    chk("midrst_hazir", {127'b0, hazir}, 128'd1);
    run_block(KC, PC, lat);
    chk("after_rst_latency", 128'(lat), 128'd10);
    chk("after_rst_sifre", sifre, CC);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_engine.md
Name: aes_engine

Overview:
- Iterative AES-128 encryption core (FIPS-197, encrypt only): one 128-bit plaintext block and one 128-bit key in, one 128-bit ciphertext block out.
- Executes one round per clock and expands round keys on the fly.
- Sits behind an input FIFO. The FIFO asserts g_gecerli when a block is available; downstream consumes sifre when c_gecerli is high.

Parameters:
- none (key size is fixed at 128 bits; 10 rounds)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- anahtar  in  128  cipher key; bits [127:120] = key byte 0
- blok  in  128  plaintext block; bits [127:120] = byte 0 (state[0][0]), FIPS column-major order
- g_gecerli  in  1  input valid; a block is accepted on a rising edge where g_gecerli=1 and hazir=1
- hazir  out  1  ready, high when idle
- sifre  out  128  ciphertext, same byte order as blok; holds the last result until the next completion
- c_gecerli  out  1  output valid; one-cycle pulse when sifre is updated

Behaviour:
- Reset (rst=0, async): state=IDLE, hazir=1, c_gecerli=0, sifre=0, round counter=0, internal state/key registers=0.
- FSM states: IDLE, BUSY.
- IDLE:
  - hazir=1.
  - On an edge with g_gecerli=1: capture state <= blok XOR anahtar and rk <= anahtar, set rnd <= 1, go to BUSY.
  - With g_gecerli=0: stay in IDLE.
- BUSY:
  - hazir=0; g_gecerli, blok and anahtar are ignored.
  - Each edge computes the next round key: rk' = KeyExpand(rk, Rcon[rnd]).
  - Rounds 1..9: state <= MixColumns(ShiftRows(SubBytes(state))) XOR rk'.
  - Round 10: the final round omits MixColumns. sifre <= ShiftRows(SubBytes(state)) XOR rk', c_gecerli <= 1, go to IDLE.
  - rnd increments each BUSY edge.
- Timing: accept at edge E0, rounds at edges E1..E10.
  - c_gecerli is high for exactly the cycle after E10; hazir returns to 1 in that same cycle.
  - A new block can be accepted at E11, giving a throughput of 1 block per 11 cycles.
- c_gecerli is registered and deasserts at the next edge unconditionally. There is no output back-pressure: downstream must capture sifre while c_gecerli=1. sifre stays stable afterwards.
- KeyExpand, with words w0..w3 where w0 = rk[127:96]:
  - t = SubWord(RotWord(w3)) XOR {Rcon,24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
  - Rcon sequence = 01,02,04,08,10,20,40,80,1B,36.
- MixColumns: GF(2^8) with polynomial 0x11B; xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0).
- Reset asserted mid-operation: the block in flight is aborted and no c_gecerli is produced. After release the core is IDLE with hazir=1.
- g_gecerli held continuously high: the core re-accepts whatever blok/anahtar present at each IDLE edge, i.e. back-to-back every 11 cycles.
- Combinational datapath: 16 S-boxes for state, plus 4 S-boxes for the key schedule.

Decomposition:
- Shared package aes_pkg holds:
  - round-count constant NR=10
  - Rcon table
  - functions xtime, mix_column (32-bit), shift_rows (128-bit), rot_word
  - enum for FSM states
- One sub-module, aes_sbox: combinational 8-bit in / 8-bit out forward S-box lookup table. It is instantiated 20 times.

Test Plan:
- Reset: hold rst=0 with g_gecerli=1 -> hazir=1, c_gecerli=0, sifre=0 throughout; no acceptance.
- FIPS-197 App. B vector:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, blok 3243f6a8885a308d313198a2e0370734, single-cycle g_gecerli.
  - Expect: sifre=3925841d02dc09fbdc118597196a0b32, with c_gecerli a one-cycle pulse 10 cycles after the accept edge. hazir=0 during the 10 BUSY cycles.
- FIPS-197 App. C.1 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, blok 00112233445566778899aabbccddeeff.
  - Expect: sifre=69c4e0d86a7b0430d8cdb78070b4c55a.
- Continuous g_gecerli=1 with key "expand 32-byte k" (6578...206b) and blok "qwertyuiopasdfgh" (7177...6768):
  - c_gecerli pulses every 11 cycles.
  - sifre matches a software AES-128 model on every pulse.
  - Changing blok while BUSY has no effect on the result.
- Mid-operation reset: assert rst=0 at round 5 of the App. B block, release, then send the App. C.1 block -> no pulse for the aborted block; the next pulse carries 69c4e0d86a7b0430d8cdb78070b4c55a.
- Idle hold: after a completion, keep g_gecerli=0 for 20 cycles -> sifre is unchanged, c_gecerli=0, hazir=1.
